// File: rtl/uart_param_if.sv
// Serial pins plus TX start/busy and RX ready/error bundle for uart_param.
// slave = UART side, master = user side (loader, bench).
interface uart_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 RxD;
  logic                 TxD_start;
  logic [DATA_BITS-1:0] TxD_data;
  logic                 TxD;
  logic                 TxD_busy;
  logic [DATA_BITS-1:0] RxD_data;
  logic                 RxD_data_ready;
  logic                 RxD_parity_err;
  logic                 RxD_frame_err;
  logic                 RxD_break;

  modport master (
    output RxD, TxD_start, TxD_data,
    input  TxD, TxD_busy, RxD_data,
    input  RxD_data_ready, RxD_parity_err,
    input  RxD_frame_err, RxD_break
  );

  modport slave (
    input  RxD, TxD_start, TxD_data,
    output TxD, TxD_busy, RxD_data,
    output RxD_data_ready, RxD_parity_err,
    output RxD_frame_err, RxD_break
  );
endinterface

// File: rtl/uart_param.sv
// Parametrised full-duplex UART: shared oversample tick, TX FSM, voting RX.
// Ports: clk, rst (sync, active high), bus (uart_param_if.slave).
module uart_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input logic         clk,
  input logic         rst,
  uart_param_if.slave bus
);
  localparam int TDIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TICK_DIV = (TDIV_RAW < 1) ? 1 : TDIV_RAW;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = $clog2(OVERSAMPLE);
  localparam int BW = 4;
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] PH_S0 = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_S1 = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_S2 = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] DB_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] SB_LAST = BW'(STOP_BITS - 1);
  localparam logic ODD = (PARITY == 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
  } tx_st_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BRK
  } rx_st_e;

  logic [CW-1:0] tck_q, tck_d;
  logic          tick;

  tx_st_e                tx_st_q, tx_st_d;
  logic [PW-1:0]         tx_ph_q, tx_ph_d;
  logic [BW-1:0]         tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]  tx_sh_q, tx_sh_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_end;
  logic                  txd;

  logic                  rx_s1_q, rx_s2_q, rx_p_q;
  rx_st_e                rx_st_q, rx_st_d;
  logic [PW-1:0]         rx_ph_q, rx_ph_d;
  logic [BW-1:0]         rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]  rx_sh_q, rx_sh_d;
  logic [1:0]            rx_smp_q, rx_smp_d;
  logic                  rx_nz_q, rx_nz_d;
  logic                  rx_pe_q, rx_pe_d;
  logic                  rx_fe_q, rx_fe_d;
  logic [DATA_BITS-1:0]  dat_q, dat_d;
  logic                  ope_q, ope_d;
  logic                  ofe_q, ofe_d;
  logic                  rdy_q, rdy_d;
  logic                  rx_end, rx_vt, rx_fall, vote;
  logic                  fe_nx, nz_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      tck_q    <= '0;
      tx_st_q  <= TX_IDLE;
      tx_ph_q  <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_par_q <= 1'b0;
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      rx_p_q   <= 1'b1;
      rx_st_q  <= RX_IDLE;
      rx_ph_q  <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
      rx_smp_q <= '0;
      rx_nz_q  <= 1'b0;
      rx_pe_q  <= 1'b0;
      rx_fe_q  <= 1'b0;
      dat_q    <= '0;
      ope_q    <= 1'b0;
      ofe_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      tck_q    <= tck_d;
      tx_st_q  <= tx_st_d;
      tx_ph_q  <= tx_ph_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      tx_par_q <= tx_par_d;
      rx_s1_q  <= bus.RxD;
      rx_s2_q  <= rx_s1_q;
      rx_p_q   <= rx_s2_q;
      rx_st_q  <= rx_st_d;
      rx_ph_q  <= rx_ph_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
      rx_smp_q <= rx_smp_d;
      rx_nz_q  <= rx_nz_d;
      rx_pe_q  <= rx_pe_d;
      rx_fe_q  <= rx_fe_d;
      dat_q    <= dat_d;
      ope_q    <= ope_d;
      ofe_q    <= ofe_d;
      rdy_q    <= rdy_d;
    end
  end

  always_comb begin
    tick  = (tck_q == CW'(TICK_DIV - 1));
    tck_d = tick ? '0 : tck_q + 1'b1;
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_par_d = tx_par_q;
    tx_end   = tick && (tx_ph_q == PH_LAST);
    tx_ph_d  = tx_end ? '0 : (tick ? tx_ph_q + 1'b1 : tx_ph_q);
    unique case (tx_st_q)
      TX_IDLE: begin
        tx_ph_d = '0;
        if (bus.TxD_start) begin
          tx_st_d  = TX_START;
          tx_bit_d = '0;
          tx_sh_d  = bus.TxD_data;
          tx_par_d = ^bus.TxD_data ^ ODD;
        end
      end
      TX_START: if (tx_end) tx_st_d = TX_DATA;
      TX_DATA: begin
        if (tx_end) begin
          tx_sh_d = tx_sh_q >> 1;
          if (tx_bit_q == DB_LAST) begin
            tx_bit_d = '0;
            tx_st_d  = (PARITY != 0) ? TX_PAR : TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
      TX_PAR: if (tx_end) tx_st_d = TX_STOP;
      TX_STOP: begin
        if (tx_end) begin
          if (tx_bit_q == SB_LAST) tx_st_d = TX_IDLE;
          else tx_bit_d = tx_bit_q + 1'b1;
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  always_comb begin
    case (tx_st_q)
      TX_START: txd = 1'b0;
      TX_DATA:  txd = tx_sh_q[0];
      TX_PAR:   txd = tx_par_q;
      default:  txd = 1'b1;
    endcase
  end

  assign bus.TxD      = txd;
  assign bus.TxD_busy = (tx_st_q != TX_IDLE);

  // Samples at OS/2-1 and OS/2 are stored; the vote happens at OS/2+1
  // using the live synchronised line as the third sample.
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_smp_d = rx_smp_q;
    rx_nz_d  = rx_nz_q;
    rx_pe_d  = rx_pe_q;
    rx_fe_d  = rx_fe_q;
    dat_d    = dat_q;
    ope_d    = ope_q;
    ofe_d    = ofe_q;
    rdy_d    = 1'b0;
    rx_fall  = rx_p_q & ~rx_s2_q;
    rx_end   = tick && (rx_ph_q == PH_LAST);
    rx_vt    = tick && (rx_ph_q == PH_S2);
    vote     = (rx_smp_q[1] & rx_smp_q[0]) |
               (rx_smp_q[1] & rx_s2_q) |
               (rx_smp_q[0] & rx_s2_q);
    fe_nx    = rx_fe_q | ~vote;
    nz_nx    = rx_nz_q | vote;
    rx_ph_d  = rx_end ? '0 : (tick ? rx_ph_q + 1'b1 : rx_ph_q);
    if (tick && (rx_ph_q == PH_S0 || rx_ph_q == PH_S1))
      rx_smp_d = {rx_smp_q[0], rx_s2_q};
    unique case (rx_st_q)
      RX_IDLE: begin
        rx_ph_d = '0;
        if (rx_fall) begin
          rx_st_d  = RX_START;
          rx_bit_d = '0;
          rx_nz_d  = 1'b0;
          rx_pe_d  = 1'b0;
          rx_fe_d  = 1'b0;
        end
      end
      RX_START: begin
        if (rx_vt && vote) rx_st_d = RX_IDLE;
        else if (rx_end) rx_st_d = RX_DATA;
      end
      RX_DATA: begin
        if (rx_vt) begin
          rx_sh_d = {vote, rx_sh_q[DATA_BITS-1:1]};
          rx_nz_d = nz_nx;
        end
        if (rx_end) begin
          if (rx_bit_q == DB_LAST) begin
            rx_bit_d = '0;
            rx_st_d  = (PARITY != 0) ? RX_PAR : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
      RX_PAR: begin
        if (rx_vt) begin
          rx_pe_d = vote ^ (^rx_sh_q) ^ ODD;
          rx_nz_d = nz_nx;
        end
        if (rx_end) rx_st_d = RX_STOP;
      end
      RX_STOP: begin
        if (rx_vt) begin
          rx_fe_d = fe_nx;
          rx_nz_d = nz_nx;
          if (rx_bit_q == SB_LAST) begin
            dat_d   = rx_sh_q;
            ope_d   = rx_pe_q;
            ofe_d   = fe_nx;
            rdy_d   = 1'b1;
            // An all-zero frame is reported once, then held off as a break.
            rx_st_d = nz_nx ? RX_IDLE : RX_BRK;
          end
        end
        if (rx_end) rx_bit_d = rx_bit_q + 1'b1;
      end
      RX_BRK: begin
        rx_ph_d = '0;
        if (rx_s2_q) rx_st_d = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  assign bus.RxD_data       = dat_q;
  assign bus.RxD_data_ready = rdy_q;
  assign bus.RxD_parity_err = ope_q;
  assign bus.RxD_frame_err  = ofe_q;
  assign bus.RxD_break      = (rx_st_q == RX_BRK);
endmodule
